// File: rtl/execute_muldiv.sv
// rtl/execute_muldiv.sv - iterative RV32M multiply/divide unit for the execute stage
module execute_muldiv #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int TAG_W          = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   opA,
    input  logic [XLEN-1:0]   opB,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              kill,
    input  logic              stall,
    output logic              hold_out,
    output logic              valid_out,
    output logic [XLEN-1:0]   result_out,
    output logic [TAG_W-1:0]  tag_out
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_REM    = 3'd6;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Iteration state: for multiply hi/lo is the 2*XLEN accumulator with the
    // multiplier in lo and opnd the multiplicand; for divide hi is the partial
    // remainder, lo shifts the dividend out and the quotient in, opnd the divisor.
    logic [CW-1:0]    count;
    logic [2:0]       op_q;
    logic [TAG_W-1:0] tag_q;
    logic             neg_q;
    logic [XLEN-1:0]  opnd_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;

    // Operand decode at the accept point
    logic             is_div_in;
    logic             a_signed, b_signed;
    logic             a_neg, b_neg;
    logic [XLEN-1:0]  a_mag, b_mag;
    logic             res_neg_in;
    logic             div_zero, div_ovf, special;
    logic [XLEN-1:0]  special_res;
    logic             accept;
    logic             finishing;

    // Iteration datapath
    logic [XLEN-1:0]   hi_s, lo_s;
    logic [XLEN:0]     shifted, diff, sum;
    logic [2*XLEN-1:0] prod, prod_c;
    logic [XLEN-1:0]   quot_c, rem_c;
    logic [XLEN-1:0]   final_res;

    // Decode signedness, magnitudes, result sign and the early-out cases
    always_comb begin
        is_div_in  = op[2];
        a_signed   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg      = a_signed && opA[XLEN-1];
        b_neg      = b_signed && opB[XLEN-1];
        a_mag      = a_neg ? (~opA + 1'b1) : opA;
        b_mag      = b_neg ? (~opB + 1'b1) : opB;
        // Remainder follows the dividend; products and quotients follow a xor b.
        res_neg_in = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
        div_zero   = is_div_in && (opB == '0);
        div_ovf    = ((op == OP_DIV) || (op == OP_REM)) && (opA == MIN_NEG) && (opB == '1);
        special    = div_zero || div_ovf;
        if (div_zero) begin
            special_res = op[1] ? opA : '1;
        end else begin
            special_res = op[1] ? '0 : opA;
        end
        accept    = start && !kill && ((state == IDLE) || ((state == DONE) && !stall));
        finishing = (state == CALC) && (count == CW'(1));
    end

    // BITS_PER_CYCLE shift-add or restoring shift-subtract steps, then sign fix-up
    always_comb begin
        hi_s    = hi_q;
        lo_s    = lo_q;
        shifted = '0;
        diff    = '0;
        sum     = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op_q[2]) begin
                shifted = {hi_s, lo_s[XLEN-1]};
                diff    = shifted - {1'b0, opnd_q};
                if (!diff[XLEN]) begin
                    hi_s = diff[XLEN-1:0];
                    lo_s = {lo_s[XLEN-2:0], 1'b1};
                end else begin
                    hi_s = shifted[XLEN-1:0];
                    lo_s = {lo_s[XLEN-2:0], 1'b0};
                end
            end else begin
                sum          = {1'b0, hi_s} + (lo_s[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
                {hi_s, lo_s} = {sum, lo_s[XLEN-1:1]};
            end
        end
        prod   = {hi_s, lo_s};
        prod_c = neg_q ? (~prod + 1'b1) : prod;
        quot_c = neg_q ? (~lo_s + 1'b1) : lo_s;
        rem_c  = neg_q ? (~hi_s + 1'b1) : hi_s;
        case (op_q)
            3'd0:                final_res = prod_c[XLEN-1:0];
            3'd1, 3'd2, 3'd3:    final_res = prod_c[2*XLEN-1:XLEN];
            3'd4, 3'd5:          final_res = quot_c;
            default:             final_res = rem_c;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; kill overrides everything but reset
    always_comb begin
        state_nxt = state;
        if (kill) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state_nxt = special ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (count == CW'(1)) begin
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    if (stall) begin
                        state_nxt = DONE;
                    end else if (accept) begin
                        state_nxt = special ? DONE : CALC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs: result is valid in DONE; hold upstream while busy or about to be
    always_comb begin
        valid_out = (state == DONE);
        hold_out  = !reset && ((state == CALC)
                            || (start && !kill && !((state == DONE) && stall))
                            || ((state == DONE) && stall));
    end

    // Operand capture, iteration, and registered result/tag
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            op_q       <= '0;
            tag_q      <= '0;
            neg_q      <= 1'b0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            result_out <= '0;
            tag_out    <= '0;
        end else if (kill) begin
            count <= '0;
        end else if (accept) begin
            op_q   <= op;
            tag_q  <= tag_in;
            neg_q  <= res_neg_in;
            hi_q   <= '0;
            opnd_q <= is_div_in ? b_mag : a_mag;
            lo_q   <= is_div_in ? a_mag : b_mag;
            if (special) begin
                count      <= '0;
                result_out <= special_res;
                tag_out    <= tag_in;
            end else begin
                count <= CW'(N);
            end
        end else if (state == CALC) begin
            hi_q  <= hi_s;
            lo_q  <= lo_s;
            count <= count - 1'b1;
            if (finishing) begin
                result_out <= final_res;
                tag_out    <= tag_q;
            end
        end
    end

endmodule

// File: doc/execute_muldiv.md
# execute_muldiv

Iterative RV32M multiply/divide unit for the execute stage. It accepts one operation per start pulse together with the instruction tag, and computes over XLEN/BITS_PER_CYCLE iterations. It holds the pipeline while busy, then presents a registered result beside the single-cycle execute units. Width and per-cycle throughput are parameters, and the unit supports flush and downstream stall.

## Interface
- XLEN, 32: operand/result width; must be even and ≥ 8.
- BITS_PER_CYCLE, 1: multiplier/quotient bits resolved per CALC cycle; one of 1, 2, 4; must divide XLEN.
- TAG_W, 4: instruction tag width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  operation request, sampled every cycle.
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- opA  in  XLEN  rs1 / dividend.
- opB  in  XLEN  rs2 / divisor.
- tag_in  in  TAG_W  instruction tag.
- kill  in  1  flush; aborts any in-flight operation.
- stall  in  1  downstream stall; freezes a finished result.
- hold_out  out  1  stall request to upstream stages (combinational).
- valid_out  out  1  result_out/tag_out valid.
- result_out  out  XLEN  result.
- tag_out  out  TAG_W  tag of the result.

## Operation
- FSM states: IDLE, CALC, DONE. Reset → IDLE.
- Accept condition: start && !kill && (IDLE || (DONE && !stall)). On accept:
  - latch op and tag_in;
  - latch |opA| and |opB| (magnitude only for signed operands: MULH/DIV/REM both signed, MULHSU opA only);
  - latch the result sign: product sign = sign(A) xor sign(B); quotient same; remainder takes sign(A).
- Special cases go to DONE directly, skipping CALC:
  - divide by zero: DIV/DIVU → all ones; REM/REMU → opA.
  - signed overflow (opA = 2^(XLEN-1), opB = −1): DIV → opA; REM → 0.
- Normal accepts load counter = XLEN/BITS_PER_CYCLE and go to CALC.
- CALC, per cycle, for BITS_PER_CYCLE steps:
  - multiply: shift-add into a 2·XLEN accumulator, LSB first.
  - divide: restoring shift-subtract, MSB first, into quotient and remainder registers.
  - counter decrements; when it reaches 1, the next state is DONE.
- Transition CALC→DONE:
  - apply sign correction (two's complement) to the 2·XLEN product, quotient or remainder;
  - select low half (MUL), high half (MULH/MULHSU/MULHU), quotient or remainder;
  - register into result_out and load tag_out.
- DONE: valid_out = 1.
  - stall: hold result_out, tag_out and valid_out unchanged; start is ignored.
  - !stall with no accept: go to IDLE.
  - !stall with accept: start the new op without passing through IDLE.
- kill, in any state, has priority over everything except reset:
  - next state IDLE, valid_out 0;
  - an op already in CALC is discarded;
  - a start in the same cycle is not accepted.
- hold_out = !reset && (CALC || (start && !kill && !(DONE && stall)) || (DONE && stall)).

## Timing
- Reset values: valid_out 0, result_out 0, tag_out 0, state IDLE, counter 0, hold_out 0.
- Latency, accept edge to first cycle with valid_out = 1:
  - normal op: N+1 edges, where N = XLEN/BITS_PER_CYCLE.
  - special case: 1 edge.
- hold_out is high for N+1 cycles on a normal op (accept cycle plus N CALC cycles), and 1 cycle on a special case. It drops in the cycle valid_out rises.
- Back-to-back ops: no bubble between DONE and the next accept.
- Reset asserted mid-CALC: IDLE and all outputs at reset values after that edge; no partial result is emitted.
- MULHSU with opB MSB set treats opB as unsigned. MUL low half is independent of sign mode.

## Test plan
- MUL opA = 7, opB = 0xFFFFFFFD → result 0xFFFFFFEB; valid_out 33 edges after accept (XLEN 32, BPC 1); hold_out high for exactly 33 cycles.
- Signed division with opA = 0xFFFFFFF9 (−7), opB = 2: DIV → 0xFFFFFFFD, REM → 0xFFFFFFFF. MULH 0xFFFFFFFF × 0xFFFFFFFF → 0. MULHU same operands → 0xFFFFFFFE.
- Special cases, each valid 1 edge after accept:
  - DIVU opA = 5, opB = 0 → 0xFFFFFFFF.
  - REM opA = 5, opB = 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Stall and back-to-back:
  - stall held 3 cycles in DONE → result_out/tag_out stable and valid_out high throughout.
  - stall release with start (DIVU 100/7, tag 5) → result 14 with tag_out 5, and no IDLE cycle between the two ops.
- kill at the 10th CALC cycle → IDLE next edge, valid_out stays 0, hold_out drops. A following DIVU 9/3 → 3.
- BITS_PER_CYCLE = 4: MULHU 0xFFFFFFFF × 2 → 1 with latency 9 edges. Reset pulse mid-CALC → all outputs 0 on the next edge.
